cic_row_readout: RTL and testbench
==================================

Name: cic_row_readout

Overview:
- Consumes the packed 24-channel x 25-bit output bus of one CIC3 filter row.
- On each decimated-sample strobe, snapshots all channels, then streams them out one word per transfer, channel 0 first, over a valid/ready interface towards the chip-level readout serializer.
- Tracks frame count and flags samples dropped while a frame is still draining.

Parameters:
- NUM_CHANNELS, 24, filter channels per row; channel k occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH] of row_data.
- DATA_WIDTH, 25, bits per filter output.
- CH_ID_WIDTH, 5, width of the channel index; must be at least clog2(NUM_CHANNELS).
- FRAME_CNT_WIDTH, 8, width of the frame sequence counter.

Ports:
- clk, input, 1, common high-speed filter clock; all logic on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- row_data, input, NUM_CHANNELS*DATA_WIDTH, packed filter outputs; stable in the cycle sample_strobe is high.
- sample_strobe, input, 1, one-cycle pulse marking a new decimated sample set.
- enable, input, 1, when low, new strobes are ignored.
- clr_overrun, input, 1, synchronous clear of overrun and drop_cnt.
- ch_data, output, DATA_WIDTH, current channel word.
- ch_id, output, CH_ID_WIDTH, index of the channel on ch_data.
- ch_valid, output, 1, ch_data/ch_id/sof/eof/frame_id are valid.
- ch_ready, input, 1, downstream accepts the word when ch_valid && ch_ready.
- sof, output, 1, high with ch_id==0.
- eof, output, 1, high with ch_id==NUM_CHANNELS-1.
- frame_id, output, FRAME_CNT_WIDTH, sequence number of the frame being sent.
- overrun, output, 1, sticky: a strobe arrived while a frame was draining.
- drop_cnt, output, 8, saturating count of dropped strobes.

Behaviour:
- Reset state: every output is 0 and the state machine is in IDLE. Internal snapshot, index and frame counter are also 0.
- States:
  - IDLE: if sample_strobe && enable, capture row_data into the snapshot, set idx=0, go to SEND.
  - SEND: ch_valid=1. A transfer happens when ch_valid && ch_ready.
    - On a transfer with idx < NUM_CHANNELS-1, idx increments.
    - On a transfer with idx == NUM_CHANNELS-1, frame_id increments (wraps modulo 2^FRAME_CNT_WIDTH) and the state returns to IDLE.
- Latency: a strobe in cycle N gives ch_valid=1 with ch_id=0 in cycle N+1. All outputs are registered.
- Output hold: ch_data, ch_id, sof and eof stay constant while ch_valid && !ch_ready (no change under backpressure).
- ch_data equals the snapshot slice of channel ch_id, not the live row_data.
- frame_id:
  - Frame 0 after reset carries frame_id=0.
  - frame_id only changes after eof is accepted.
- Strobe during SEND, not coincident with the final transfer:
  - The snapshot is not overwritten.
  - overrun is set.
  - drop_cnt increments, saturating at 255.
  - The new sample is lost.
- Strobe coincident with the final (eof) transfer:
  - Not an overrun. The snapshot is recaptured, idx=0, the state stays SEND, and ch_valid stays 1.
  - The next cycle presents ch_id=0 of the new frame with frame_id incremented.
- Strobe with enable=0: ignored, with no overrun and no drop count.
- enable falling mid-frame: the current frame completes normally.
- clr_overrun:
  - Clears overrun and drop_cnt next cycle.
  - If it coincides with an overrun event, the set wins: overrun=1, drop_cnt=1.
- Reset asserted mid-frame: the frame is abandoned immediately and all outputs go to 0. After release, the first strobe starts frame_id=0.
- Throughput: with ch_ready held high, a frame takes exactly NUM_CHANNELS cycles. Strobe spacing must be at least NUM_CHANNELS cycles to avoid overrun.

Test Plan:
- Basic frame:
  - Stimulus: row_data channel k = k*0x10001 masked to 25 bits; one strobe; ch_ready=1.
  - Response: 24 consecutive valid cycles starting 1 cycle after the strobe; ch_id 0..23; data matches; sof on ch 0, eof on ch 23; frame_id=0; then IDLE.
- Backpressure and snapshot:
  - Stimulus: toggle ch_ready in a 1010 pattern; change row_data after the strobe.
  - Response: outputs hold while not ready; all 24 words equal the captured values; transfers take 48 cycles.
- Overrun:
  - Stimulus: hold ch_ready=0; issue strobes 3 and 10 cycles into the frame.
  - Response: overrun=1, drop_cnt=2; the frame still carries the original snapshot.
  - Then pulse clr_overrun: overrun=0, drop_cnt=0.
- Back-to-back:
  - Stimulus: strobe every 24 cycles with ch_ready=1, so each strobe coincides with eof acceptance.
  - Response: continuous ch_valid; frame_id 0,1,2,…; overrun stays 0.
- Enable and wrap:
  - Stimulus: 256 frames with enable=1, then one strobe with enable=0.
  - Response: frame_id wraps 255→0; the disabled strobe produces no frame.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 at ch_id=7.
  - Response: ch_valid=0 asynchronously; after release, the next strobe gives sof with frame_id=0.

Source files
------------

// File: rtl/cic_row_readout.sv
// Row readout for one CIC3 filter row: snapshots all channel outputs on a
// decimated-sample strobe and streams them channel 0 first over valid/ready.
module cic_row_readout #(
   parameter int unsigned NUM_CHANNELS    = 24,
   parameter int unsigned DATA_WIDTH      = 25,
   parameter int unsigned CH_ID_WIDTH     = 5,
   parameter int unsigned FRAME_CNT_WIDTH = 8
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] row_data,
   input  logic                               sample_strobe,
   input  logic                               enable,
   input  logic                               clr_overrun,
   output logic [DATA_WIDTH-1:0]              ch_data,
   output logic [CH_ID_WIDTH-1:0]             ch_id,
   output logic                               ch_valid,
   input  logic                               ch_ready,
   output logic                               sof,
   output logic                               eof,
   output logic [FRAME_CNT_WIDTH-1:0]         frame_id,
   output logic                               overrun,
   output logic [7:0]                         drop_cnt
);

   localparam logic [CH_ID_WIDTH-1:0] LAST_ID = CH_ID_WIDTH'(NUM_CHANNELS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                            state, state_nxt;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0] snap, snap_nxt;
   logic [CH_ID_WIDTH-1:0]            idx_nxt;
   logic [FRAME_CNT_WIDTH-1:0]        frame_nxt;
   logic [DATA_WIDTH-1:0]             data_nxt;
   logic                              strobe_ok;
   logic                              drop_evt;

   assign strobe_ok = sample_strobe && enable;
   assign ch_valid  = (state == SEND);

   always_comb begin
      state_nxt = state;
      snap_nxt  = snap;
      idx_nxt   = ch_id;
      frame_nxt = frame_id;
      drop_evt  = 1'b0;
      case (state)
         IDLE: begin
            if (strobe_ok) begin
               snap_nxt  = row_data;
               idx_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (ch_ready && (ch_id == LAST_ID)) begin
               frame_nxt = frame_id + FRAME_CNT_WIDTH'(1);
               // A strobe landing on the eof transfer chains straight into the next frame.
               if (strobe_ok) begin
                  snap_nxt = row_data;
                  idx_nxt  = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               if (ch_ready) begin
                  idx_nxt = ch_id + CH_ID_WIDTH'(1);
               end
               drop_evt = strobe_ok;
            end
         end
         default: state_nxt = IDLE;
      endcase

      data_nxt = '0;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
         if (idx_nxt == CH_ID_WIDTH'(k)) begin
            data_nxt = snap_nxt[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         snap     <= '0;
         ch_id    <= '0;
         ch_data  <= '0;
         sof      <= 1'b0;
         eof      <= 1'b0;
         frame_id <= '0;
         overrun  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         state    <= state_nxt;
         snap     <= snap_nxt;
         ch_id    <= idx_nxt;
         ch_data  <= data_nxt;
         sof      <= (state_nxt == SEND) && (idx_nxt == '0);
         eof      <= (state_nxt == SEND) && (idx_nxt == LAST_ID);
         frame_id <= frame_nxt;
         // A drop in the same cycle as a clear restarts the count at one.
         if (drop_evt) begin
            overrun <= 1'b1;
            if (clr_overrun) begin
               drop_cnt <= 8'd1;
            end else if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end else if (clr_overrun) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cic_row_readout.sv
// Scoreboard bench for cic_row_readout: directed frames are queued as expected
// words and a negedge monitor pops and compares every accepted transfer.
module tb_cic_row_readout;

   localparam int unsigned NCH = 24;
   localparam int unsigned DW  = 25;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [4:0]    id;
      logic          sof;
      logic          eof;
      logic [7:0]    fid;
   } exp_t;

   logic              clk;
   logic              reset_n;
   logic [NCH*DW-1:0] row_data;
   logic              sample_strobe;
   logic              enable;
   logic              clr_overrun;
   logic [DW-1:0]     ch_data;
   logic [4:0]        ch_id;
   logic              ch_valid;
   logic              ch_ready;
   logic              sof;
   logic              eof;
   logic [7:0]        frame_id;
   logic              overrun;
   logic [7:0]        drop_cnt;

   int   errors = 0;
   int   checks = 0;
   exp_t sbq[$];
   exp_t e;

   logic          stall_q = 1'b0;
   logic [DW-1:0] h_data;
   logic [4:0]    h_id;
   logic          h_sof, h_eof;
   logic [7:0]    h_fid;

   cic_row_readout #(
      .NUM_CHANNELS    (NCH),
      .DATA_WIDTH      (DW),
      .CH_ID_WIDTH     (5),
      .FRAME_CNT_WIDTH (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .row_data      (row_data),
      .sample_strobe (sample_strobe),
      .enable        (enable),
      .clr_overrun   (clr_overrun),
      .ch_data       (ch_data),
      .ch_id         (ch_id),
      .ch_valid      (ch_valid),
      .ch_ready      (ch_ready),
      .sof           (sof),
      .eof           (eof),
      .frame_id      (frame_id),
      .overrun       (overrun),
      .drop_cnt      (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] chval(input int unsigned k, input int unsigned seed);
      return DW'(k * 32'h10001 + seed);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_row(input int unsigned seed);
      for (int unsigned k = 0; k < NCH; k++) row_data[k*DW +: DW] = chval(k, seed);
   endtask

   task automatic push_frame(input int unsigned seed, input int unsigned fid, input int unsigned n);
      exp_t x;
      for (int unsigned k = 0; k < n; k++) begin
         x.data = chval(k, seed);
         x.id   = 5'(k);
         x.sof  = (k == 0);
         x.eof  = (k == NCH - 1);
         x.fid  = 8'(fid);
         sbq.push_back(x);
      end
   endtask

   task automatic strobe(input logic en);
      sample_strobe = 1'b1;
      enable        = en;
      tick();
      sample_strobe = 1'b0;
      enable        = 1'b1;
   endtask

   task automatic wait_idle(input int unsigned limit);
      int unsigned n = 0;
      while (ch_valid && n < limit) begin
         tick();
         n++;
      end
      chk("idle_timeout", 32'(ch_valid), 32'd0);
   endtask

   // Monitor: hold check under backpressure, then scoreboard pop on each transfer.
   always @(negedge clk) begin
      if (!reset_n) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            checks++;
            if (!(ch_valid && ch_data == h_data && ch_id == h_id && sof == h_sof &&
                  eof == h_eof && frame_id == h_fid)) begin
               errors++;
               $display("FAIL hold: got v=%0b id=%0d d=%0h sof=%0b eof=%0b fid=%0d expected id=%0d d=%0h sof=%0b eof=%0b fid=%0d",
                        ch_valid, ch_id, ch_data, sof, eof, frame_id, h_id, h_data, h_sof, h_eof, h_fid);
            end
         end
         if (ch_valid && ch_ready) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got id=%0d d=%0h fid=%0d expected no transfer", ch_id, ch_data, frame_id);
            end else begin
               e = sbq.pop_front();
               if (ch_data !== e.data || ch_id !== e.id || sof !== e.sof || eof !== e.eof || frame_id !== e.fid) begin
                  errors++;
                  $display("FAIL word: got id=%0d d=%0h sof=%0b eof=%0b fid=%0d expected id=%0d d=%0h sof=%0b eof=%0b fid=%0d",
                           ch_id, ch_data, sof, eof, frame_id, e.id, e.data, e.sof, e.eof, e.fid);
               end
            end
         end
         stall_q = ch_valid && !ch_ready;
         h_data  = ch_data;
         h_id    = ch_id;
         h_sof   = sof;
         h_eof   = eof;
         h_fid   = frame_id;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of stimulus expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned cyc;
      int unsigned gaps;

      reset_n       = 1'b0;
      row_data      = '0;
      sample_strobe = 1'b0;
      enable        = 1'b1;
      clr_overrun   = 1'b0;
      ch_ready      = 1'b1;
      repeat (3) tick();
      chk("rst_valid", 32'(ch_valid), 32'd0);
      chk("rst_id", 32'(ch_id), 32'd0);
      chk("rst_data", 32'(ch_data), 32'd0);
      chk("rst_sof_eof", {30'd0, sof, eof}, 32'd0);
      chk("rst_fid", 32'(frame_id), 32'd0);
      chk("rst_ovr", {23'd0, overrun, drop_cnt}, 32'd0);
      reset_n = 1'b1;
      tick();

      // Basic frame
      set_row(0);
      push_frame(0, 0, NCH);
      strobe(1'b1);
      chk("lat_valid", 32'(ch_valid), 32'd1);
      chk("lat_id", 32'(ch_id), 32'd0);
      chk("lat_sof", 32'(sof), 32'd1);
      repeat (23) tick();
      chk("basic_last_id", 32'(ch_id), 32'd23);
      chk("basic_eof", 32'(eof), 32'd1);
      tick();
      chk("basic_idle", 32'(ch_valid), 32'd0);
      chk("basic_q", 32'(sbq.size()), 32'd0);

      // Backpressure with live data changing after capture
      set_row(32'h55);
      push_frame(32'h55, 1, NCH);
      strobe(1'b1);
      set_row(32'hAAA);
      cyc = 0;
      while (ch_valid && cyc < 100) begin
         ch_ready = cyc[0];
         tick();
         cyc++;
      end
      chk("bp_cycles", cyc, 32'd48);
      chk("bp_q", 32'(sbq.size()), 32'd0);

      // Overrun, clear/set collision and saturation while stalled
      ch_ready = 1'b1;
      tick();
      ch_ready = 1'b0;
      set_row(32'h123);
      push_frame(32'h123, 2, NCH);
      strobe(1'b1);
      set_row(32'h777);
      repeat (2) tick();
      strobe(1'b1);
      repeat (6) tick();
      strobe(1'b1);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_cnt", 32'(drop_cnt), 32'd2);
      sample_strobe = 1'b1;
      clr_overrun   = 1'b1;
      tick();
      sample_strobe = 1'b0;
      clr_overrun   = 1'b0;
      chk("ovr_setwins_flag", 32'(overrun), 32'd1);
      chk("ovr_setwins_cnt", 32'(drop_cnt), 32'd1);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk("clr_flag", 32'(overrun), 32'd0);
      chk("clr_cnt", 32'(drop_cnt), 32'd0);
      sample_strobe = 1'b1;
      repeat (260) tick();
      sample_strobe = 1'b0;
      chk("sat_cnt", 32'(drop_cnt), 32'd255);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      chk("clr2_cnt", 32'(drop_cnt), 32'd0);
      ch_ready = 1'b1;
      wait_idle(200);
      chk("ovr_q", 32'(sbq.size()), 32'd0);

      // Back-to-back frames across frame_id wrap
      gaps = 0;
      for (int unsigned f = 0; f < 256; f++) begin
         set_row(f * 32'h100);
         push_frame(f * 32'h100, (f + 3) % 256, NCH);
         sample_strobe = 1'b1;
         tick();
         sample_strobe = 1'b0;
         if (!ch_valid) gaps++;
         for (int unsigned c = 0; c < 23; c++) begin
            tick();
            if (!ch_valid) gaps++;
         end
      end
      chk("b2b_gaps", gaps, 32'd0);
      chk("b2b_ovr", {23'd0, overrun, drop_cnt}, 32'd0);
      wait_idle(50);
      chk("wrap_fid", 32'(frame_id), 32'd3);
      chk("b2b_q", 32'(sbq.size()), 32'd0);

      // Disabled strobe
      set_row(32'hBEEF);
      strobe(1'b0);
      repeat (3) tick();
      chk("dis_valid", 32'(ch_valid), 32'd0);
      chk("dis_ovr", {23'd0, overrun, drop_cnt}, 32'd0);
      chk("dis_fid", 32'(frame_id), 32'd3);

      // Reset mid-frame at ch_id 7
      set_row(32'h4242);
      push_frame(32'h4242, 3, 7);
      strobe(1'b1);
      repeat (7) tick();
      chk("pre_rst_id", 32'(ch_id), 32'd7);
      reset_n = 1'b0;
      #1;
      chk("async_valid", 32'(ch_valid), 32'd0);
      chk("async_id", 32'(ch_id), 32'd0);
      chk("async_data", 32'(ch_data), 32'd0);
      chk("async_fid", 32'(frame_id), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      set_row(32'h99);
      push_frame(32'h99, 0, NCH);
      strobe(1'b1);
      chk("post_rst_sof", 32'(sof), 32'd1);
      chk("post_rst_fid", 32'(frame_id), 32'd0);
      wait_idle(50);
      chk("final_q", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
